// File: rtl/drv_led.sv
// Multi-channel LED driver: steady-on, free-running blink, and a counted flash
// sequence that overrides a latched subset of channels. Output is registered.
module drv_led #(
    parameter int unsigned p_width   = 4,
    parameter int unsigned p_divider = 17_865_771,
    parameter string       p_mode    = "activehigh"
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [p_width-1:0] i_on,
    input  logic [p_width-1:0] i_blink,
    input  logic               i_flash_start,
    input  logic [p_width-1:0] i_flash_mask,
    input  logic [3:0]         i_flash_count,
    output logic               o_busy,
    output logic [p_width-1:0] o_drv_led
);

    localparam int unsigned          c_cnt_w = $clog2(p_divider);
    localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(p_divider - 1);
    localparam logic [c_cnt_w-1:0]   c_one   = c_cnt_w'(1);
    // Anything other than "activelow" drives active-high.
    localparam bit                   c_low   = (p_mode == "activelow");
    localparam logic [p_width-1:0]   c_pol   = {p_width{c_low}};

    typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

    logic [c_cnt_w-1:0] blink_cnt_q;
    logic               blink_phase_q;
    logic               blink_tick;

    state_e             state_q, state_d;
    logic [c_cnt_w-1:0] phase_q, phase_d;
    logic [3:0]         remain_q, remain_d;
    logic [p_width-1:0] mask_q, mask_d;
    logic [p_width-1:0] led_q, led_d;
    logic [p_width-1:0] led_val;
    logic               phase_done;

    assign blink_tick = (blink_cnt_q == c_last);
    assign phase_done = (phase_q == c_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_tick) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + c_one;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        mask_d   = mask_q;
        case (state_q)
            StIdle: begin
                if (i_flash_start && (i_flash_count != 4'd0)) begin
                    mask_d   = i_flash_mask;
                    remain_d = i_flash_count;
                    phase_d  = '0;
                    state_d  = StOn;
                end
            end
            StOn: begin
                if (phase_done) begin
                    phase_d = '0;
                    state_d = StOff;
                end else begin
                    phase_d = phase_q + c_one;
                end
            end
            StOff: begin
                if (phase_done) begin
                    phase_d = '0;
                    if (remain_q == 4'd1) begin
                        state_d = StIdle;
                    end else begin
                        remain_d = remain_q - 4'd1;
                        state_d  = StOn;
                    end
                end else begin
                    phase_d = phase_q + c_one;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Flash overrides only the latched channels; the rest keep on/blink behaviour.
    always_comb begin
        led_val = i_on | (i_blink & {p_width{blink_phase_q}});
        if (state_q == StOn) begin
            led_val = led_val | mask_q;
        end else if (state_q == StOff) begin
            led_val = led_val & ~mask_q;
        end
        led_d = led_val ^ c_pol;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            remain_q <= 4'd0;
            mask_q   <= '0;
            led_q    <= c_pol;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
            mask_q   <= mask_d;
            led_q    <= led_d;
        end
    end

    assign o_busy    = (state_q != StIdle);
    assign o_drv_led = led_q;

endmodule
